// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver feeding the receive FIFO write port.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 27,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Rx_In,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 rx_meta;
  logic                 rx_sync;
  logic [2:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 tick;
  logic                 mid;
  logic                 exp_par;

  assign tick    = (state != S_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign mid     = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
  assign exp_par = (^shreg) ^ (PARITY_ODD != 0);
  assign Busy    = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= Rx_In;
      rx_sync <= rx_meta;
    end
  end

  // Counters idle at zero, so entering START starts a fresh tick/bit phase.
  // OC keeps wrapping through the frame: the start mid-sample at OVERSAMPLE/2-1
  // lands every later sample at the middle of its bit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (state == S_IDLE) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      os_cnt  <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_err    <= 1'b0;
      Rx_Data    <= '0;
      Data_Rdy   <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      Data_Rdy   <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          par_err <= 1'b0;
          if (!rx_sync) state <= S_START;
        end
        S_START: begin
          if (mid) state <= rx_sync ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (mid) begin
            shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BC_W'(DATA_BITS - 1))
              state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (mid) begin
            par_err <= (rx_sync != exp_par);
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (mid) begin
            if (!rx_sync) begin
              Frame_Err <= 1'b1;
              state     <= S_BREAK;
            end else begin
              if (par_err) begin
                Parity_Err <= 1'b1;
              end else begin
                Rx_Data  <= shreg;
                Data_Rdy <= 1'b1;
              end
              state <= S_IDLE;
            end
          end
        end
        S_BREAK: begin
          if (rx_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx : directed vector bench for uart_rx (CLK_DIV=4, OVERSAMPLE=16).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       data_rdy, parity_err, frame_err, busy;

  uart_rx #(
    .DATA_BITS(8), .OVERSAMPLE(16), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .Rx_In(rx_in), .Rx_Data(rx_data),
    .Data_Rdy(data_rdy), .Parity_Err(parity_err), .Frame_Err(frame_err), .Busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0, perr_cnt = 0, ferr_cnt = 0, proto_err = 0;
  int last_rdy_cyc = 0;
  int start_cyc = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] rdy_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_rdy) begin
        rdy_cnt++;
        rdy_q.push_back(rx_data);
        last_rdy_cyc = cyc;
      end
      if (parity_err) perr_cnt++;
      if (frame_err) ferr_cnt++;
      if (int'(data_rdy) + int'(parity_err) + int'(frame_err) > 1) proto_err++;
      if (prev_pulse && (data_rdy || parity_err || frame_err)) proto_err++;
      prev_pulse = data_rdy | parity_err | frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    rx_in = 1'b0;
    start_cyc = cyc;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         exp_rdy;
    int         exp_perr;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int r0, p0, f0, lat;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 0, 1, 8'hA5};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1, 0, 8'h01};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 1, 0, 8'h5A};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 0, 1, 8'h5A};
    vecs[5] = '{8'h7E, 1'b0, 1'b1, 1, 0, 8'h7E};

    repeat (5) @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_flags", {data_rdy, parity_err, frame_err}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      r0 = rdy_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      rx_in = 1'b1;
      repeat (16) @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), rdy_cnt - r0, vecs[i].exp_rdy);
      chk($sformatf("vec%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
      chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, 0);
      chk($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      chk($sformatf("vec%0d_busy", i), busy, 0);
      if (i == 0) begin
        lat = last_rdy_cyc - start_cyc;
        chk($sformatf("latency_%0d_in_674_676", lat), (lat >= 674 && lat <= 676), 1);
      end
    end

    // Stop bit low, then line held low: one Frame_Err, stuck in BREAK.
    r0 = rdy_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    chk("break_ferr", ferr_cnt - f0, 1);
    chk("break_rdy", rdy_cnt - r0, 0);
    chk("break_perr", perr_cnt - p0, 0);
    chk("break_busy", busy, 1);
    chk("break_rx_data", rx_data, 8'h7E);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("break_exit_busy", busy, 0);

    // Glitch shorter than half a bit is a false start.
    r0 = rdy_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    rx_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy_during", busy, 1);
    rx_in = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_pulses", (rdy_cnt - r0) + (perr_cnt - p0) + (ferr_cnt - f0), 0);
    send_frame(8'h01, 1'b1, 1'b1);
    rx_in = 1'b1;
    repeat (16) @(negedge clk);
    chk("after_glitch_rdy", rdy_cnt - r0, 1);
    chk("after_glitch_rx_data", rx_data, 8'h01);

    // Back-to-back frames with no idle gap.
    rdy_q.delete();
    p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    rx_in = 1'b1;
    repeat (16) @(negedge clk);
    chk("b2b_count", rdy_q.size(), 3);
    if (rdy_q.size() == 3) begin
      chk("b2b_word0", rdy_q[0], 8'h00);
      chk("b2b_word1", rdy_q[1], 8'hFF);
      chk("b2b_word2", rdy_q[2], 8'h81);
    end
    chk("b2b_flags", (perr_cnt - p0) + (ferr_cnt - f0), 0);

    // Reset in the middle of the data bits of a 0x99 frame.
    r0 = rdy_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_rx_data", rx_data, 8'h00);
    chk("reset_mid_flags", {data_rdy, parity_err, frame_err}, 0);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    chk("post_reset_pulses", (rdy_cnt - r0) + (perr_cnt - p0) + (ferr_cnt - f0), 0);
    chk("post_reset_busy", busy, 0);
    send_frame(8'h42, 1'b0, 1'b1);
    rx_in = 1'b1;
    repeat (16) @(negedge clk);
    chk("post_reset_rdy", rdy_cnt - r0, 1);
    chk("post_reset_rx_data", rx_data, 8'h42);

    chk("pulse_protocol", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
